// File: rtl/debounce_pkg.sv
// +----------------------------------------------------------------------------+
// | debounce_pkg                                                               |
// | Shared state encodings and defaults for the multi-channel debouncer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package debounce_pkg;

  localparam int DEFAULT_N = 3;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT0 = 2'b01,
    ONE   = 2'b10,
    WAIT1 = 2'b11
  } db_state_t;

  // The debounced level is high while settled high or while qualifying a fall.
  function automatic logic level_of(input db_state_t s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_chan.sv
// +----------------------------------------------------------------------------+
// | debounce_chan                                                              |
// | One debounce channel: 4-state FSM, N-bit down-counter, edge tick flops.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module debounce_chan
  import debounce_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [N-1:0] C_CNT_ONE = N'(1);
  localparam logic [N-1:0] C_CNT_ALL = '1;

  db_state_t      r_state;
  logic [N-1:0]   r_cnt;
  logic           r_rise;
  logic           r_fall;
  logic [N-1:0]   w_cnt_dec;

  assign w_cnt_dec = r_cnt - C_CNT_ONE;

  // Counter only moves in WAIT states with a matching sample, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ZERO: begin
          if (sw) begin
            r_state <= WAIT1;
            r_cnt   <= C_CNT_ALL;
          end
        end
        WAIT1: begin
          if (sw) begin
            r_cnt <= w_cnt_dec;
            if (w_cnt_dec == '0) begin
              r_state <= ONE;
              r_rise  <= 1'b1;
            end
          end else begin
            r_state <= ZERO;
          end
        end
        ONE: begin
          if (!sw) begin
            r_state <= WAIT0;
            r_cnt   <= C_CNT_ALL;
          end
        end
        WAIT0: begin
          if (!sw) begin
            r_cnt <= w_cnt_dec;
            if (w_cnt_dec == '0) begin
              r_state <= ZERO;
              r_fall  <= 1'b1;
            end
          end else begin
            r_state <= ONE;
          end
        end
        default: r_state <= ZERO;
      endcase
    end
  end

  assign level = level_of(r_state);
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/debounce_multi.sv
// +----------------------------------------------------------------------------+
// | debounce_multi                                                             |
// | CH independent switch debouncers with level, rise and fall outputs.        |
// | Optional 2-flop input synchroniser enabled by DEBOUNCE_SYNC_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CH = 4,
  parameter int N  = DEFAULT_N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] db_rise,
  output logic [CH-1:0] db_fall
);

  logic [CH-1:0] w_sw_fsm;

`ifdef DEBOUNCE_SYNC_EN
  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sw_fsm = r_sync2;
`else
  assign w_sw_fsm = sw;
`endif

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    debounce_chan #(
      .N(N)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .sw    (w_sw_fsm[gi]),
      .level (db_level[gi]),
      .rise  (db_rise[gi]),
      .fall  (db_fall[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// +----------------------------------------------------------------------------+
// | tb_debounce_multi                                                          |
// | Scoreboard bench for debounce_multi with directed stimulus.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_debounce_multi;

  localparam int CH  = 4;
  localparam int N   = 3;
  localparam int WIN = 1 << N;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] sw    = '0;
  logic [CH-1:0] db_level;
  logic [CH-1:0] db_rise;
  logic [CH-1:0] db_fall;

  debounce_multi #(
    .CH(CH),
    .N (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .db_rise  (db_rise),
    .db_fall  (db_fall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: a level flips once WIN consecutive samples disagree with it.
  logic [CH-1:0] m_lvl;
  int            m_run [CH];
  logic [CH-1:0] m_s1;
  logic [CH-1:0] m_s2;

  task automatic model_reset();
    m_lvl = '0;
    m_s1  = '0;
    m_s2  = '0;
    for (int i = 0; i < CH; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [CH-1:0] v, output exp_t e);
    logic [CH-1:0] x;
`ifdef DEBOUNCE_SYNC_EN
    x    = m_s2;
    m_s2 = m_s1;
    m_s1 = v;
`else
    x = v;
`endif
    e.rise = '0;
    e.fall = '0;
    for (int i = 0; i < CH; i++) begin
      if (x[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == WIN) begin
          m_lvl[i] = x[i];
          m_run[i] = 0;
          if (x[i]) e.rise[i] = 1'b1;
          else      e.fall[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    e.lvl = m_lvl;
  endtask

  task automatic drive(input logic [CH-1:0] v);
    exp_t e;
    sw = v;
    model_edge(v, e);
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [CH-1:0] v);
    @(negedge clk);
    drive(v);
  endtask

  task automatic hold(input logic [CH-1:0] v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge carries one expected output triple.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({db_level, db_rise, db_fall} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got lvl=%b rise=%b fall=%b expected lvl=%b rise=%b fall=%b at %0t",
                   db_level, db_rise, db_fall, e.lvl, e.rise, e.fall, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] v;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_level", db_level, 4'b0000);
    check("reset_rise",  db_rise,  4'b0000);
    check("reset_fall",  db_fall,  4'b0000);

    @(negedge clk);
    reset = 1'b0;
    drive(4'b0000);
    hold(4'b0000, 2);

    // Channel 0 qualifies high after WIN (+sync) edges.
    hold(4'b0001, WIN + LAT - 1);
    settle();
    check("ch0_before_window", db_level, 4'b0000);
    step(4'b0001);
    settle();
    check("ch0_level_up", db_level, 4'b0001);
    check("ch0_rise_tick", db_rise, 4'b0001);
    check("ch0_no_fall", db_fall, 4'b0000);
    step(4'b0001);
    settle();
    check("ch0_rise_one_cycle", db_rise, 4'b0000);

    // Channel 1 high for one cycle short of the window.
    hold(4'b0011, WIN - 1);
    hold(4'b0001, 12);
    settle();
    check("ch1_short_pulse_level", db_level, 4'b0001);

    // Channel 0 low glitch, then a full low window.
    hold(4'b0000, 5);
    hold(4'b0001, 10);
    settle();
    check("ch0_glitch_level", db_level, 4'b0001);
    hold(4'b0000, WIN + LAT - 1);
    settle();
    check("ch0_fall_pending", db_level, 4'b0001);
    step(4'b0000);
    settle();
    check("ch0_level_down", db_level, 4'b0000);
    check("ch0_fall_tick", db_fall, 4'b0001);
    step(4'b0000);
    settle();
    check("ch0_fall_one_cycle", db_fall, 4'b0000);

    // Reset while channel 2 is mid-wait and channel 3 is high.
    hold(4'b1000, WIN + LAT);
    hold(4'b1100, 4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midwait_reset_level", db_level, 4'b0000);
    check("midwait_reset_rise",  db_rise,  4'b0000);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(4'b1100);
    hold(4'b1100, WIN + LAT - 2);
    settle();
    check("post_reset_pending", db_level, 4'b0000);
    step(4'b1100);
    settle();
    check("post_reset_level", db_level, 4'b1100);
    check("post_reset_rise",  db_rise,  4'b1100);

    // Concurrent bounce patterns across all channels.
    for (int t = 0; t < 80; t++) begin
      v[0] = (t >= 2) && (t != 6) && (t < 50);
      v[1] = ((t / 3) % 2) == 1;
      v[2] = ((t >= 4) && (t < 13)) || ((t >= 30) && (t < 40));
      v[3] = (t % 20) < 10;
      step(v);
    end
    hold(4'b0000, WIN + LAT + 2);
    settle();
    check("final_level", db_level, 4'b0000);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
